// File: rtl/rob_param.sv
// In-order-commit reorder buffer: out-of-order writeback, single retire per cycle, store release and mispredict flush.
// Retire/flush pulses are registered one edge after the head is ready; rob_full is advisory, dispatch at count==DEPTH is dropped. Option: ROB_PERF_CNT_EN.
module rob_param #(
    parameter int DEPTH       = 16,
    parameter int TAG_W       = 5,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int REG_W       = 5,
    parameter int FULL_MARGIN = 3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              disp_valid,
    input  logic [ADDR_W-1:0] disp_npc,
    input  logic [REG_W-1:0]  disp_rd,
    input  logic              disp_is_load,
    input  logic              disp_is_store,
    output logic [TAG_W-1:0]  next_tag,
    output logic              rob_full,
    input  logic              alu_wb_valid,
    input  logic [TAG_W-1:0]  alu_wb_tag,
    input  logic [DATA_W-1:0] alu_wb_val,
    input  logic [ADDR_W-1:0] alu_wb_npc,
    input  logic              lsb_wb_valid,
    input  logic [TAG_W-1:0]  lsb_wb_tag,
    input  logic [DATA_W-1:0] lsb_wb_val,
    input  logic [TAG_W-1:0]  q1_tag,
    input  logic [TAG_W-1:0]  q2_tag,
    output logic              q1_ready,
    output logic              q2_ready,
    output logic [DATA_W-1:0] q1_val,
    output logic [DATA_W-1:0] q2_val,
    output logic              commit_valid,
    output logic [REG_W-1:0]  commit_rd,
    output logic [DATA_W-1:0] commit_val,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [TAG_W-1:0]  head_tag,
    output logic              store_rel_valid,
    output logic [TAG_W-1:0]  store_rel_tag,
    input  logic              store_rel_ack,
    output logic              flush,
    output logic [ADDR_W-1:0] redirect_pc
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_commits,
    output logic [31:0]       perf_flushes
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {ST_EMPTY, ST_ISSUED, ST_DONE} ent_state_t;

    ent_state_t        st      [DEPTH];
    logic [ADDR_W-1:0] npc_q   [DEPTH];
    logic [ADDR_W-1:0] rnpc_q  [DEPTH];
    logic [REG_W-1:0]  rd_q    [DEPTH];
    logic [DATA_W-1:0] val_q   [DEPTH];
    logic              is_load_q  [DEPTH];
    logic              is_store_q [DEPTH];

    logic [IDX_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    logic             do_commit, do_store_ret, retire, mispred, do_disp;
    logic             alu_wr, lsb_wr;
    logic [IDX_W-1:0] a_idx, l_idx;

    function automatic logic tag_ok(input logic [TAG_W-1:0] t);
        return (t != '0) && (int'(t) <= DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [TAG_W-1:0] t);
        return IDX_W'(t - TAG_W'(1));
    endfunction

    // Returns {ready, value}; the live writeback buses take priority over stored entries.
    function automatic logic [DATA_W:0] lookup(input logic [TAG_W-1:0] t);
        logic [DATA_W:0] res;
        res = '0;
        if (t == '0)
            res = {1'b1, {DATA_W{1'b0}}};
        else if (alu_wb_valid && alu_wb_tag == t)
            res = {1'b1, alu_wb_val};
        else if (lsb_wb_valid && lsb_wb_tag == t)
            res = {1'b1, lsb_wb_val};
        else if (tag_ok(t) && st[idx_of(t)] == ST_DONE)
            res = {1'b1, val_q[idx_of(t)]};
        return res;
    endfunction

    assign next_tag        = TAG_W'(tail) + TAG_W'(1);
    assign head_tag        = TAG_W'(head) + TAG_W'(1);
    assign rob_full        = count >= CNT_W'(DEPTH - FULL_MARGIN);
    assign store_rel_valid = (st[head] != ST_EMPTY) && is_store_q[head];
    assign store_rel_tag   = store_rel_valid ? head_tag : '0;

    always_comb begin
        {q1_ready, q1_val} = lookup(q1_tag);
        {q2_ready, q2_val} = lookup(q2_tag);
    end

    always_comb begin
        a_idx        = idx_of(alu_wb_tag);
        l_idx        = idx_of(lsb_wb_tag);
        do_commit    = rdy_in && (st[head] == ST_DONE) && !is_store_q[head];
        do_store_ret = rdy_in && store_rel_valid && store_rel_ack;
        retire       = do_commit || do_store_ret;
        mispred      = do_commit && (rnpc_q[head] != npc_q[head]);
        do_disp      = rdy_in && disp_valid && (count != CNT_W'(DEPTH)) && !flush && !mispred;
        lsb_wr       = rdy_in && !mispred && lsb_wb_valid && tag_ok(lsb_wb_tag)
                       && (st[l_idx] == ST_ISSUED) && !(retire && l_idx == head);
        alu_wr       = rdy_in && !mispred && alu_wb_valid && tag_ok(alu_wb_tag)
                       && (st[a_idx] == ST_ISSUED) && !(retire && a_idx == head)
                       && !(lsb_wb_valid && lsb_wb_tag == alu_wb_tag);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_val   <= '0;
            commit_tag   <= '0;
            flush        <= 1'b0;
            redirect_pc  <= '0;
            for (int i = 0; i < DEPTH; i++) st[i] <= ST_EMPTY;
        end else if (!rdy_in) begin
            commit_valid <= 1'b0;
            flush        <= 1'b0;
        end else begin
            commit_valid <= retire;
            flush        <= mispred;
            if (retire) begin
                commit_rd  <= do_store_ret ? '0 : rd_q[head];
                commit_val <= val_q[head];
                commit_tag <= head_tag;
            end
            if (mispred) begin
                redirect_pc <= rnpc_q[head];
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                for (int i = 0; i < DEPTH; i++) st[i] <= ST_EMPTY;
            end else begin
                if (retire) begin
                    st[head] <= ST_EMPTY;
                    head     <= head + IDX_W'(1);
                end
                if (do_disp) begin
                    st[tail] <= ST_ISSUED;
                    tail     <= tail + IDX_W'(1);
                end
                if (alu_wr) st[a_idx] <= ST_DONE;
                if (lsb_wr) st[l_idx] <= ST_DONE;
                case ({do_disp, retire})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Payload storage; validity is carried entirely by st[].
    always_ff @(posedge clk_in) begin
        if (do_disp) begin
            npc_q[tail]      <= disp_npc;
            rnpc_q[tail]     <= disp_npc;
            rd_q[tail]       <= disp_rd;
            val_q[tail]      <= '0;
            is_load_q[tail]  <= disp_is_load;
            is_store_q[tail] <= disp_is_store;
        end
        if (alu_wr) begin
            val_q[a_idx] <= alu_wb_val;
            // A load's control flow never resolves on the ALU bus.
            if (!is_load_q[a_idx]) rnpc_q[a_idx] <= alu_wb_npc;
        end
        if (lsb_wr) val_q[l_idx] <= lsb_wb_val;
    end

`ifdef ROB_PERF_CNT_EN
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            perf_commits <= '0;
            perf_flushes <= '0;
        end else begin
            if (retire && perf_commits != '1) perf_commits <= perf_commits + 32'd1;
            if (mispred && perf_flushes != '1) perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rob_param.sv
// Bench for rob_param: directed scenarios plus random traffic checked against a queue-based ROB model.
module tb_rob_param;
    localparam int DEPTH = 16;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        disp_valid, disp_is_load, disp_is_store;
    logic [31:0] disp_npc;
    logic [4:0]  disp_rd;
    logic [4:0]  next_tag, head_tag, commit_tag, store_rel_tag, commit_rd;
    logic        rob_full, commit_valid, store_rel_valid, flush;
    logic        alu_wb_valid, lsb_wb_valid, store_rel_ack;
    logic [4:0]  alu_wb_tag, lsb_wb_tag, q1_tag, q2_tag;
    logic [31:0] alu_wb_val, alu_wb_npc, lsb_wb_val;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_val, q2_val, commit_val, redirect_pc;

    always #5 clk_in = ~clk_in;

    rob_param dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .disp_valid(disp_valid), .disp_npc(disp_npc), .disp_rd(disp_rd),
        .disp_is_load(disp_is_load), .disp_is_store(disp_is_store),
        .next_tag(next_tag), .rob_full(rob_full),
        .alu_wb_valid(alu_wb_valid), .alu_wb_tag(alu_wb_tag), .alu_wb_val(alu_wb_val), .alu_wb_npc(alu_wb_npc),
        .lsb_wb_valid(lsb_wb_valid), .lsb_wb_tag(lsb_wb_tag), .lsb_wb_val(lsb_wb_val),
        .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_val(q1_val), .q2_val(q2_val),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_val(commit_val), .commit_tag(commit_tag),
        .head_tag(head_tag), .store_rel_valid(store_rel_valid), .store_rel_tag(store_rel_tag),
        .store_rel_ack(store_rel_ack), .flush(flush), .redirect_pc(redirect_pc)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: the occupied ROB as an ordered list, oldest first.
    typedef struct {
        int          tag;
        logic [31:0] npc, rnpc, val;
        logic [4:0]  rd;
        bit          st, ld, done;
    } ent_t;

    ent_t mq[$];
    int   nt   = 1;
    bit   m_fl = 0;
    int   clog[$];

    function automatic int find(input int t);
        for (int i = 0; i < mq.size(); i++) if (mq[i].tag == t) return i;
        return -1;
    endfunction

    function automatic void look(input logic [4:0] t, output logic r, output logic [31:0] v);
        int i;
        r = 1'b0; v = '0;
        if (t == 0) r = 1'b1;
        else if (alu_wb_valid && alu_wb_tag == t) begin r = 1'b1; v = alu_wb_val; end
        else if (lsb_wb_valid && lsb_wb_tag == t) begin r = 1'b1; v = lsb_wb_val; end
        else begin
            i = find(int'(t));
            if (i >= 0 && mq[i].done) begin r = 1'b1; v = mq[i].val; end
        end
    endfunction

    task automatic idle();
        rdy_in = 1'b1; disp_valid = 0; disp_npc = '0; disp_rd = '0; disp_is_load = 0; disp_is_store = 0;
        alu_wb_valid = 0; alu_wb_tag = '0; alu_wb_val = '0; alu_wb_npc = '0;
        lsb_wb_valid = 0; lsb_wb_tag = '0; lsb_wb_val = '0;
        q1_tag = '0; q2_tag = '0; store_rel_ack = 0;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        int sz, i, ht;
        bit cm, sr, mis, e_cv, e_fl;
        logic r;
        logic [31:0] v, e_rd, e_val, e_tag, e_rpc;
        ent_t e;
        mis = 0; e_cv = 0; e_fl = 0; e_rd = 0; e_val = 0; e_tag = 0; e_rpc = 0;
        #1;
        if (rst_in) begin
            ht = nt;
            if (mq.size() > 0) ht = mq[0].tag;
            chk("next_tag", next_tag, nt);
            chk("head_tag", head_tag, ht);
            chk("rob_full", rob_full, 32'(mq.size() >= DEPTH - 3));
            sr = mq.size() > 0 && mq[0].st;
            chk("store_rel_valid", store_rel_valid, 32'(sr));
            if (sr) chk("store_rel_tag", store_rel_tag, mq[0].tag);
            look(q1_tag, r, v); chk("q1_ready", q1_ready, r); chk("q1_val", q1_val, v);
            look(q2_tag, r, v); chk("q2_ready", q2_ready, r); chk("q2_val", q2_val, v);
        end
        if (!rst_in) begin
            mq.delete(); nt = 1; m_fl = 0;
        end else if (rdy_in) begin
            sz = mq.size();
            cm = sz > 0 && !mq[0].st && mq[0].done;
            sr = sz > 0 && mq[0].st && store_rel_ack;
            if (cm || sr) begin
                e_cv = 1; e_rd = sr ? 0 : mq[0].rd; e_val = mq[0].val; e_tag = mq[0].tag;
                mis = cm && (mq[0].rnpc != mq[0].npc); e_rpc = mq[0].rnpc;
                void'(mq.pop_front());
            end
            if (mis) begin
                mq.delete(); nt = 1;
            end else begin
                if (alu_wb_valid && !(lsb_wb_valid && lsb_wb_tag == alu_wb_tag)) begin
                    i = find(int'(alu_wb_tag));
                    if (i >= 0 && !mq[i].done) begin
                        mq[i].val = alu_wb_val; mq[i].rnpc = alu_wb_npc; mq[i].done = 1;
                    end
                end
                if (lsb_wb_valid) begin
                    i = find(int'(lsb_wb_tag));
                    if (i >= 0 && !mq[i].done) begin mq[i].val = lsb_wb_val; mq[i].done = 1; end
                end
                if (disp_valid && sz < DEPTH && !m_fl) begin
                    e.tag = nt; e.npc = disp_npc; e.rnpc = disp_npc; e.val = 0; e.rd = disp_rd;
                    e.st = disp_is_store; e.ld = disp_is_load; e.done = 0;
                    mq.push_back(e);
                    nt = nt % DEPTH + 1;
                end
            end
            e_fl = mis; m_fl = mis;
        end else begin
            m_fl = 0;
        end
        @(posedge clk_in); #1;
        chk("commit_valid", commit_valid, e_cv);
        chk("flush", flush, e_fl);
        if (e_cv) begin
            chk("commit_rd", commit_rd, e_rd);
            chk("commit_val", commit_val, e_val);
            chk("commit_tag", commit_tag, e_tag);
        end
        if (e_fl) chk("redirect_pc", redirect_pc, e_rpc);
        if (commit_valid) clog.push_back(int'(commit_tag));
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        idle(); rst_in = 0;
        cycle();
        chk("rst_commit_valid", commit_valid, 0); chk("rst_commit_rd", commit_rd, 0);
        chk("rst_commit_val", commit_val, 0);     chk("rst_commit_tag", commit_tag, 0);
        chk("rst_flush", flush, 0);               chk("rst_redirect", redirect_pc, 0);
        chk("rst_store_rel_valid", store_rel_valid, 0); chk("rst_store_rel_tag", store_rel_tag, 0);
        chk("rst_rob_full", rob_full, 0);
        chk("rst_next_tag", next_tag, 1);         chk("rst_head_tag", head_tag, 1);
        rst_in = 1;
    endtask

    task automatic dispatch(input logic [31:0] npc, input logic [4:0] rd, input bit ld, input bit st);
        idle(); disp_valid = 1; disp_npc = npc; disp_rd = rd; disp_is_load = ld; disp_is_store = st;
        cycle();
    endtask

    task automatic alu_wb(input int t, input logic [31:0] val, input logic [31:0] npc);
        idle(); alu_wb_valid = 1; alu_wb_tag = 5'(t); alu_wb_val = val; alu_wb_npc = npc;
        cycle();
    endtask

    task automatic rand_inputs();
        int i, t;
        idle();
        rdy_in        = $urandom_range(0, 9) != 0;
        disp_valid    = mq.size() < DEPTH && $urandom_range(0, 1) == 1;
        disp_npc      = $urandom;
        disp_rd       = 5'($urandom);
        disp_is_store = $urandom_range(0, 4) == 0;
        disp_is_load  = !disp_is_store && $urandom_range(0, 2) == 0;
        if (mq.size() > 0 && $urandom_range(0, 2) != 0) begin
            i = $urandom_range(0, mq.size() - 1);
            if (!mq[i].ld) begin
                alu_wb_valid = 1; alu_wb_tag = 5'(mq[i].tag); alu_wb_val = $urandom;
                alu_wb_npc = ($urandom_range(0, 7) == 0) ? mq[i].npc + 4 : mq[i].npc;
            end
        end else if ($urandom_range(0, 9) == 0) begin
            t = $urandom_range(1, DEPTH);
            if (find(t) < 0) begin
                alu_wb_valid = 1; alu_wb_tag = 5'(t); alu_wb_val = $urandom; alu_wb_npc = $urandom;
            end
        end
        if (mq.size() > 0) begin
            i = $urandom_range(0, mq.size() - 1);
            if (mq[i].ld && $urandom_range(0, 1) == 1) begin
                lsb_wb_valid = 1; lsb_wb_tag = 5'(mq[i].tag); lsb_wb_val = $urandom;
            end
        end
        store_rel_ack = $urandom_range(0, 1) == 1;
        q1_tag = 5'($urandom_range(0, DEPTH));
        q2_tag = 5'($urandom_range(0, DEPTH));
    endtask

    initial begin
        int lt;
        idle(); rst_in = 0;
        @(negedge clk_in);
        do_reset();

        // Out-of-order writeback, in-order commit.
        clog.delete();
        for (int k = 0; k < 3; k++) dispatch(32'h1000 + 32'(4 * k), 5'(k + 1), 0, 0);
        alu_wb(3, 32'hA3, 32'h1008);
        alu_wb(1, 32'hA1, 32'h1000);
        alu_wb(2, 32'hA2, 32'h1004);
        idle(); repeat (3) cycle();
        chk("t1_commit_count", clog.size(), 3);
        for (int k = 0; k < 3; k++) if (k < clog.size()) chk("t1_order", clog[k], k + 1);

        // Fill to capacity, overflow dispatch, drain and wrap.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            dispatch(32'h2000 + 32'(4 * k), 5'(k), 0, 0);
            if (k == 12) chk("full_at_13", rob_full, 1);
            if (k == 11) chk("not_full_at_12", rob_full, 0);
        end
        chk("full_next_tag", next_tag, 1);
        for (int t = 1; t <= 16; t++) alu_wb(t, 32'(t), 32'h2000 + 32'(4 * (t - 1)));
        idle(); repeat (3) cycle();
        chk("drain_head_tag", head_tag, 1);
        chk("drain_full", rob_full, 0);
        dispatch(32'h3000, 5'd1, 0, 0);
        dispatch(32'h3004, 5'd2, 0, 0);
        chk("wrap_next_tag", next_tag, 3);

        // Mispredict flush; dispatch during flush is dropped.
        do_reset();
        dispatch(32'h100, 5'd4, 0, 0);
        dispatch(32'h104, 5'd5, 0, 0);
        alu_wb(1, 32'h55, 32'h200);
        idle(); cycle();
        chk("br_flush", flush, 1);
        chk("br_redirect", redirect_pc, 32'h200);
        dispatch(32'h300, 5'd6, 0, 0);
        chk("br_flush_drop", next_tag, 1);
        chk("br_flush_pulse", flush, 0);
        dispatch(32'h300, 5'd6, 0, 0);
        chk("br_post_disp", next_tag, 2);

        // Store release handshake.
        do_reset();
        dispatch(32'h400, 5'd7, 0, 1);
        dispatch(32'h404, 5'd3, 0, 0);
        alu_wb(2, 32'h77, 32'h404);
        for (int k = 0; k < 5; k++) begin
            idle(); cycle();
            chk("st_hold_valid", store_rel_valid, 1);
            chk("st_hold_no_commit", commit_valid, 0);
        end
        idle(); store_rel_ack = 1; cycle();
        chk("st_ack_commit", commit_valid, 1);
        chk("st_ack_rd", commit_rd, 0);
        chk("st_ack_tag", commit_tag, 1);
        idle(); cycle();

        // Same-cycle forwarding and LSB-wins collision.
        idle(); q1_tag = 5'd4; q2_tag = 5'd0; alu_wb_valid = 1; alu_wb_tag = 5'd4; alu_wb_val = 32'hDEAD;
        #1;
        chk("fwd_q1_ready", q1_ready, 1); chk("fwd_q1_val", q1_val, 32'hDEAD);
        chk("fwd_q2_ready", q2_ready, 1); chk("fwd_q2_val", q2_val, 0);
        cycle();
        lt = nt;
        dispatch(32'h500, 5'd9, 1, 0);
        idle(); q1_tag = 5'(lt);
        alu_wb_valid = 1; alu_wb_tag = 5'(lt); alu_wb_val = 32'h1111; alu_wb_npc = 32'h500;
        lsb_wb_valid = 1; lsb_wb_tag = 5'(lt); lsb_wb_val = 32'h2222;
        #1; chk("fwd_alu_first", q1_val, 32'h1111);
        cycle();
        idle(); cycle();
        chk("lsb_wins", commit_val, 32'h2222);

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            rand_inputs();
            cycle();
        end

        // Reset during a pending store release.
        do_reset();
        dispatch(32'h600, 5'd2, 0, 1);
        idle(); cycle();
        chk("pend_store_valid", store_rel_valid, 1);
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
